// File: rtl/blinker_pkg.sv
// Shared encodings and helpers for the multi-channel status blinker.
package blinker_pkg;

  localparam int HALF_W  = 16;
  localparam int COUNT_W = 4;

  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_ON    = 2'd1;
  localparam logic [1:0] MODE_BLINK = 2'd2;
  localparam logic [1:0] MODE_BURST = 2'd3;

  typedef enum logic [1:0] {
    B_ON  = 2'd0,
    B_OFF = 2'd1,
    B_GAP = 2'd2
  } burst_state_e;

  // A programmed half-period of zero behaves as one tick.
  function automatic logic [HALF_W-1:0] eff_half(input logic [HALF_W-1:0] half);
    return (half == HALF_W'(0)) ? HALF_W'(1) : half;
  endfunction

  // Output level a channel takes immediately after being configured.
  function automatic logic initial_level(input logic [1:0] mode,
                                         input logic [COUNT_W-1:0] count);
    return (mode == MODE_ON) || (mode == MODE_BLINK) ||
           ((mode == MODE_BURST) && (count != COUNT_W'(0)));
  endfunction

endpackage

// File: rtl/blinker_channel.sv
// One LED channel: config registers, half-period timer, burst FSM and output flop.
module blinker_channel
  import blinker_pkg::*;
#(
  parameter int GAP_HALVES = 4,
  parameter int RST_HALF   = 500
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick_i,
  input  logic               enable_i,
  input  logic               we_i,
  input  logic [1:0]         mode_i,
  input  logic [HALF_W-1:0]  half_i,
  input  logic [COUNT_W-1:0] count_i,
  output logic               out_o
);

  localparam int GAP_W = (GAP_HALVES > 1) ? $clog2(GAP_HALVES + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_HALVES);

  logic [1:0]         mode_q, mode_d;
  logic [HALF_W-1:0]  half_q, half_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [HALF_W-1:0]  tmr_q, tmr_d;
  logic [COUNT_W-1:0] pulse_q, pulse_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  burst_state_e       bst_q, bst_d;
  logic               out_q, out_d;

  logic              step_s;
  logic              expire_s;
  logic [HALF_W-1:0] tmr_next_s;

  assign step_s     = tick_i & enable_i;
  assign expire_s   = (tmr_q == (eff_half(half_q) - HALF_W'(1)));
  assign tmr_next_s = expire_s ? HALF_W'(0) : (tmr_q + HALF_W'(1));

  // Next-state: a config write overrides any tick arriving in the same cycle.
  always_comb begin
    mode_d  = mode_q;
    half_d  = half_q;
    count_d = count_q;
    tmr_d   = tmr_q;
    pulse_d = pulse_q;
    gap_d   = gap_q;
    bst_d   = bst_q;
    out_d   = out_q;
    if (we_i) begin
      mode_d  = mode_i;
      half_d  = half_i;
      count_d = count_i;
      tmr_d   = HALF_W'(0);
      pulse_d = COUNT_W'(0);
      gap_d   = GAP_W'(0);
      bst_d   = B_ON;
      out_d   = initial_level(mode_i, count_i);
    end else if (step_s && (mode_q == MODE_BLINK)) begin
      tmr_d = tmr_next_s;
      if (expire_s) begin
        out_d = ~out_q;
      end else begin
        out_d = out_q;
      end
    end else if (step_s && (mode_q == MODE_BURST) && (count_q != COUNT_W'(0))) begin
      tmr_d = tmr_next_s;
      if (expire_s) begin
        case (bst_q)
          B_ON: begin
            bst_d   = B_OFF;
            out_d   = 1'b0;
            pulse_d = pulse_q + COUNT_W'(1);
          end
          B_OFF: begin
            if (pulse_q == count_q) begin
              bst_d   = B_GAP;
              pulse_d = COUNT_W'(0);
              gap_d   = GAP_W'(0);
              out_d   = 1'b0;
            end else begin
              bst_d = B_ON;
              out_d = 1'b1;
            end
          end
          B_GAP: begin
            if ((gap_q + GAP_W'(1)) >= GAP_LAST) begin
              bst_d = B_ON;
              gap_d = GAP_W'(0);
              out_d = 1'b1;
            end else begin
              gap_d = gap_q + GAP_W'(1);
            end
          end
          default: begin
            bst_d = B_ON;
            out_d = 1'b1;
          end
        endcase
      end else begin
        bst_d = bst_q;
      end
    end else begin
      out_d = out_q;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q  <= MODE_OFF;
      half_q  <= HALF_W'(RST_HALF);
      count_q <= COUNT_W'(0);
      tmr_q   <= HALF_W'(0);
      pulse_q <= COUNT_W'(0);
      gap_q   <= GAP_W'(0);
      bst_q   <= B_ON;
      out_q   <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      half_q  <= half_d;
      count_q <= count_d;
      tmr_q   <= tmr_d;
      pulse_q <= pulse_d;
      gap_q   <= gap_d;
      bst_q   <= bst_d;
      out_q   <= out_d;
    end
  end

  assign out_o = out_q;

endmodule

// File: rtl/status_blinker.sv
// Multi-channel heartbeat / status-LED generator: shared tick prescaler,
// config-write decode, and one blinker_channel per output.
module status_blinker
  import blinker_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int TICK_HZ     = 1000,
  parameter int CHANNELS    = 4,
  parameter int GAP_HALVES  = 4,
  parameter int RST_HALF    = 500,
  localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [HALF_W-1:0]   cfg_half,
  input  logic [COUNT_W-1:0]  cfg_count,
  output logic                tick_out,
  output logic [CHANNELS-1:0] blink_out
);

  localparam int TICK_DIV = CLK_FREQ_HZ / TICK_HZ;
  localparam int PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0]    pre_q, pre_d;
  logic                tick_q, tick_d;
  logic [CHANNELS-1:0] we_vec_s;

  // Prescaler next-state: wrap produces the tick, disable freezes the count.
  always_comb begin
    pre_d  = pre_q;
    tick_d = 1'b0;
    if (enable) begin
      if (pre_q == PRE_LAST) begin
        pre_d  = PRE_W'(0);
        tick_d = 1'b1;
      end else begin
        pre_d = pre_q + PRE_W'(1);
      end
    end else begin
      pre_d = pre_q;
    end
  end

  // Prescaler and tick registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_q  <= PRE_W'(0);
      tick_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      tick_q <= tick_d;
    end
  end

  assign tick_out = tick_q;

  // Out-of-range channel numbers match no strobe and are dropped.
  always_comb begin
    we_vec_s = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      we_vec_s[i] = cfg_we & (cfg_ch == CH_W'(i));
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    blinker_channel #(
      .GAP_HALVES (GAP_HALVES),
      .RST_HALF   (RST_HALF)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .tick_i   (tick_q),
      .enable_i (enable),
      .we_i     (we_vec_s[g]),
      .mode_i   (cfg_mode),
      .half_i   (cfg_half),
      .count_i  (cfg_count),
      .out_o    (blink_out[g])
    );
  end

endmodule

// File: tb/tb_status_blinker.sv
// Directed bench for status_blinker with TICK_DIV = 10, three channels, gap of 4.
module tb_status_blinker;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [1:0]  cfg_mode;
  logic [15:0] cfg_half;
  logic [3:0]  cfg_count;
  logic        tick_out;
  logic [2:0]  blink_out;

  int checks = 0;
  int errors = 0;

  status_blinker #(
    .CLK_FREQ_HZ (1000),
    .TICK_HZ     (100),
    .CHANNELS    (3),
    .GAP_HALVES  (4),
    .RST_HALF    (500)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_mode  (cfg_mode),
    .cfg_half  (cfg_half),
    .cfg_count (cfg_count),
    .tick_out  (tick_out),
    .blink_out (blink_out)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic [1:0] mode,
                           input logic [15:0] half, input logic [3:0] cnt);
    cfg_ch = ch; cfg_mode = mode; cfg_half = half; cfg_count = cnt;
    cfg_we = 1'b1;
    step(1);
    cfg_we = 1'b0;
  endtask

  // Leaves time just after the edge on which tick_out rose.
  task automatic sync_tick(output bit found);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step(1);
      if (tick_out === 1'b1) found = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; enable = 1'b1; cfg_we = 1'b0;
    cfg_ch = 2'd0; cfg_mode = 2'd0; cfg_half = 16'd0; cfg_count = 4'd0;
    step(3);
    checks++; if (tick_out !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b want 0", tick_out); end
    checks++; if (blink_out !== 3'b000) begin errors++; $display("FAIL reset_blink: got %b want 000", blink_out); end
    rst = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      step(1);
      checks++;
      if (tick_out !== ((k % 10) == 0)) begin
        errors++; $display("FAIL tick_cycle%0d: got %b want %b", k, tick_out, ((k % 10) == 0));
      end
    end
    checks++; if (blink_out !== 3'b000) begin errors++; $display("FAIL idle_blink: got %b want 000", blink_out); end
    cfg_write(2'd0, 2'd1, 16'd5, 4'd0);
    checks++; if (blink_out !== 3'b001) begin errors++; $display("FAIL on_before_rst: got %b want 001", blink_out); end
    step(9);
    checks++; if (tick_out !== 1'b1) begin errors++; $display("FAIL tick_cycle40: got %b want 1", tick_out); end
    rst = 1'b0;
    #1;
    checks++; if (tick_out !== 1'b0) begin errors++; $display("FAIL midrst_tick: got %b want 0", tick_out); end
    checks++; if (blink_out !== 3'b000) begin errors++; $display("FAIL midrst_blink: got %b want 000", blink_out); end
    step(2);
    rst = 1'b1;
  endtask

  task automatic test_blink;
    bit found;
    sync_tick(found);
    checks++; if (!found) begin errors++; $display("FAIL blink_sync: got 0 want 1"); end
    step(1);
    cfg_write(2'd0, 2'd2, 16'd3, 4'd0);  // write edge W
    checks++; if (blink_out !== 3'b001) begin errors++; $display("FAIL blink_start: got %b want 001", blink_out); end
    step(28);
    checks++; if (blink_out !== 3'b001) begin errors++; $display("FAIL blink_w28: got %b want 001", blink_out); end
    step(1);
    checks++; if (blink_out !== 3'b000) begin errors++; $display("FAIL blink_w29: got %b want 000", blink_out); end
    step(29);
    checks++; if (blink_out !== 3'b000) begin errors++; $display("FAIL blink_w58: got %b want 000", blink_out); end
    step(1);
    checks++; if (blink_out !== 3'b001) begin errors++; $display("FAIL blink_w59: got %b want 001", blink_out); end
    step(30);
    checks++; if (blink_out !== 3'b000) begin errors++; $display("FAIL blink_w89: got %b want 000", blink_out); end
  endtask

  // Continues from W+89; the unfrozen next toggle would be at W+119.
  task automatic test_freeze;
    step(3);
    enable = 1'b0;
    for (int k = 0; k < 25; k++) begin
      step(1);
      checks++;
      if (tick_out !== 1'b0 || blink_out !== 3'b000) begin
        errors++; $display("FAIL freeze_hold%0d: got tick %b blink %b want tick 0 blink 000", k, tick_out, blink_out);
      end
    end
    enable = 1'b1;
    step(26);
    checks++; if (blink_out !== 3'b000) begin errors++; $display("FAIL freeze_w143: got %b want 000", blink_out); end
    step(1);
    checks++; if (blink_out !== 3'b001) begin errors++; $display("FAIL freeze_w144: got %b want 001", blink_out); end
  endtask

  task automatic test_burst;
    bit found;
    logic [7:0] seq;
    logic [2:0] exp;
    seq = 8'b0000_0101;
    sync_tick(found);
    checks++; if (!found) begin errors++; $display("FAIL burst_sync: got 0 want 1"); end
    step(1);
    cfg_write(2'd0, 2'd0, 16'd1, 4'd0);
    cfg_write(2'd1, 2'd3, 16'd1, 4'd2);
    for (int j = 0; j <= 16; j++) begin
      if (j != 0) step(10);
      exp = {1'b0, seq[j % 8], 1'b0};
      checks++;
      if (blink_out !== exp) begin
        errors++; $display("FAIL burst_tick%0d: got %b want %b", j, blink_out, exp);
      end
    end
    cfg_write(2'd1, 2'd0, 16'd1, 4'd0);
  endtask

  task automatic test_back_to_back;
    bit found;
    sync_tick(found);
    checks++; if (!found) begin errors++; $display("FAIL coll_sync0: got 0 want 1"); end
    step(1);
    cfg_write(2'd0, 2'd2, 16'd1, 4'd0);
    sync_tick(found);
    checks++; if (!found) begin errors++; $display("FAIL coll_sync1: got 0 want 1"); end
    cfg_write(2'd2, 2'd2, 16'd2, 4'd0);  // lands on the tick edge
    checks++; if (blink_out !== 3'b100) begin errors++; $display("FAIL coll_t0: got %b want 100", blink_out); end
    step(10);
    checks++; if (blink_out !== 3'b101) begin errors++; $display("FAIL coll_t1: got %b want 101", blink_out); end
    step(10);
    checks++; if (blink_out !== 3'b000) begin errors++; $display("FAIL coll_t2: got %b want 000", blink_out); end
    step(10);
    checks++; if (blink_out !== 3'b001) begin errors++; $display("FAIL coll_t3: got %b want 001", blink_out); end
    cfg_write(2'd3, 2'd1, 16'd1, 4'd1);
    checks++; if (blink_out !== 3'b001) begin errors++; $display("FAIL bad_ch_now: got %b want 001", blink_out); end
    step(9);
    checks++; if (blink_out !== 3'b100) begin errors++; $display("FAIL bad_ch_t4: got %b want 100", blink_out); end
  endtask

  task automatic test_corners;
    bit found;
    sync_tick(found);
    checks++; if (!found) begin errors++; $display("FAIL corner_sync: got 0 want 1"); end
    step(1);
    cfg_write(2'd0, 2'd0, 16'd1, 4'd0);
    cfg_write(2'd2, 2'd0, 16'd1, 4'd0);
    cfg_write(2'd1, 2'd2, 16'd0, 4'd0);
    checks++; if (blink_out !== 3'b010) begin errors++; $display("FAIL half0_start: got %b want 010", blink_out); end
    step(8);
    checks++; if (blink_out !== 3'b000) begin errors++; $display("FAIL half0_t1: got %b want 000", blink_out); end
    step(10);
    checks++; if (blink_out !== 3'b010) begin errors++; $display("FAIL half0_t2: got %b want 010", blink_out); end
    step(10);
    checks++; if (blink_out !== 3'b000) begin errors++; $display("FAIL half0_t3: got %b want 000", blink_out); end
    cfg_write(2'd1, 2'd0, 16'd1, 4'd0);
    cfg_write(2'd2, 2'd3, 16'd1, 4'd0);
    checks++; if (blink_out !== 3'b000) begin errors++; $display("FAIL cnt0_start: got %b want 000", blink_out); end
    step(10);
    checks++; if (blink_out !== 3'b000) begin errors++; $display("FAIL cnt0_t1: got %b want 000", blink_out); end
    step(10);
    checks++; if (blink_out !== 3'b000) begin errors++; $display("FAIL cnt0_t2: got %b want 000", blink_out); end
    cfg_write(2'd0, 2'd1, 16'd1, 4'd0);
    checks++; if (blink_out !== 3'b001) begin errors++; $display("FAIL on_start: got %b want 001", blink_out); end
    step(10);
    checks++; if (blink_out !== 3'b001) begin errors++; $display("FAIL on_t1: got %b want 001", blink_out); end
    step(10);
    checks++; if (blink_out !== 3'b001) begin errors++; $display("FAIL on_t2: got %b want 001", blink_out); end
    cfg_write(2'd0, 2'd0, 16'd1, 4'd0);
    checks++; if (blink_out !== 3'b000) begin errors++; $display("FAIL off_after_on: got %b want 000", blink_out); end
  endtask

  initial begin
    test_reset;
    test_blink;
    test_freeze;
    test_burst;
    test_back_to_back;
    test_corners;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
